// File: rtl/aes_inv_cipher_top_if.sv
// Host-side bundle for the AES-128 inverse cipher: key load, block load and plaintext return.
// The master drives strobes and data; the slave returns status pulses and the plaintext.
interface aes_inv_cipher_top_if;
   logic         kld;
   logic [127:0] key;
   logic         kdone;
   logic         ld;
   logic [127:0] text_in;
   logic         busy;
   logic         done;
   logic [127:0] text_out;

   modport master (output kld, key, ld, text_in, input kdone, busy, done, text_out);
   modport slave  (input kld, key, ld, text_in, output kdone, busy, done, text_out);
endinterface

// File: rtl/aes_inv_cipher_top.sv
// AES-128 decryption, one round per clock. Key expansion: kdone 12 cycles after kld. Block: done 12 cycles after ld.
// No backpressure: ld is taken only in READY (including the done cycle); kld always wins and aborts.
module aes_inv_cipher_top (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_inv_cipher_top_if.slave  bus
);
   typedef enum logic [1:0] {K_IDLE, K_EXP, READY, DEC} state_e;

   state_e       state_q;
   logic [127:0] rk_q [0:10];
   logic [127:0] w_q;
   logic [7:0]   rcon_q;
   logic [3:0]   cnt_q;
   logic [127:0] st_q;
   logic         kdone_q, done_q, busy_q;
   logic [127:0] text_out_q;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // a^254 is the field inverse; zero maps to zero as AES requires
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r, p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   // Constant multiply built from the xtime chain a, 2a, 4a, 8a
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] w, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
      n0 = w[127:96] ^ t;
      n1 = w[95:64]  ^ n0;
      n2 = w[63:32]  ^ n1;
      n3 = w[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Row r rotates right by r: out(r,c) = in(r,(c-r) mod 4), then inverse S-box
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = gm(a[r], 4'he) ^ gm(a[(r+1)%4], 4'hb) ^
                                    gm(a[(r+2)%4], 4'hd) ^ gm(a[(r+3)%4], 4'h9);
      end
      return o;
   endfunction

   logic [3:0]   rk_idx;
   logic [127:0] rk_sel, sb_ark, round_d;

   // cnt 0: whitening with rk[10]; cnt 1..9: full rounds; cnt 10: final round with rk[0]
   always_comb begin
      rk_idx  = (cnt_q <= 4'd10) ? (4'd10 - cnt_q) : 4'd0;
      rk_sel  = rk_q[rk_idx];
      sb_ark  = inv_shift_sub(st_q) ^ rk_sel;
      round_d = inv_mix(sb_ark);
      if (cnt_q == 4'd0)       round_d = st_q ^ rk_sel;
      else if (cnt_q == 4'd10) round_d = sb_ark;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= K_IDLE;
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
         w_q        <= '0;
         rcon_q     <= '0;
         cnt_q      <= '0;
         st_q       <= '0;
         kdone_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         text_out_q <= '0;
      end else begin
         kdone_q <= 1'b0;
         done_q  <= 1'b0;
         if (bus.kld) begin
            state_q <= K_EXP;
            w_q     <= bus.key;
            rcon_q  <= 8'h01;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               K_EXP: begin
                  if (cnt_q == 4'd11) begin
                     kdone_q <= 1'b1;
                     state_q <= READY;
                  end else begin
                     rk_q[cnt_q] <= w_q;
                     w_q         <= key_next(w_q, rcon_q);
                     rcon_q      <= xt(rcon_q);
                     cnt_q       <= cnt_q + 4'd1;
                  end
               end
               READY: begin
                  busy_q <= bus.ld;
                  if (bus.ld) begin
                     st_q    <= bus.text_in;
                     cnt_q   <= '0;
                     state_q <= DEC;
                  end
               end
               DEC: begin
                  // busy stays high through the done cycle
                  if (cnt_q == 4'd11) begin
                     text_out_q <= st_q;
                     done_q     <= 1'b1;
                     state_q    <= READY;
                  end else begin
                     st_q  <= round_d;
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= K_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.kdone    = kdone_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.text_out = text_out_q;
endmodule
